// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: word sizes, the NOP encoding and the
// queue slot record used by the fetch buffer.
package fetch_pkg;

   localparam int XLEN    = 32;
   localparam int ILEN    = 32;
   localparam int PC_STEP = 4;
   localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] data;
      logic            filled;
   } fetch_slot_t;

   // Clears the byte-offset bits so every fetch address is word aligned.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return pc & ~XLEN'(PC_STEP - 1);
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch stage's memory, redirect and decode handshake signals.
// master = the fetch unit, slave = memory/decode/branch environment.
interface instruction_fetch_if;
   import fetch_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [ILEN-1:0] imem_rdata;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            inst_valid;
   logic            inst_ready;
   logic [ILEN-1:0] instruction;
   logic [XLEN-1:0] inst_pc;
   logic            misaligned;

   modport master (
      output imem_req, imem_addr, inst_valid, instruction, inst_pc, misaligned,
      input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, instruction, inst_pc, misaligned,
      output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
   );

endinterface

// File: rtl/fetch_queue.sv
// Reserved-slot in-order buffer: a slot is reserved with its PC at grant time,
// filled in order when the word returns, and popped from the head once filled.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   reserve,
   input  logic [XLEN-1:0]        reserve_pc,
   input  logic                   fill,
   input  logic [ILEN-1:0]        fill_data,
   input  logic                   pop,
   output logic                   head_valid,
   output logic [XLEN-1:0]        head_pc,
   output logic [ILEN-1:0]        head_data,
   output logic [$clog2(DEPTH):0] slots
);

   localparam int PW = $clog2(DEPTH);

   fetch_slot_t    mem [DEPTH];
   logic [PW-1:0]  head;
   logic [PW-1:0]  tail;
   logic [PW-1:0]  fill_ptr;

   // Reserve, fill and pop touch different slots whenever they coincide, so all
   // three may act in the same cycle; flush wins over everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         head     <= '0;
         tail     <= '0;
         fill_ptr <= '0;
         slots    <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) mem[i].filled <= 1'b0;
         head     <= '0;
         tail     <= '0;
         fill_ptr <= '0;
         slots    <= '0;
      end else begin
         if (reserve) begin
            mem[tail] <= '{pc: reserve_pc, data: '0, filled: 1'b0};
            tail      <= tail + 1'b1;
         end
         if (fill) begin
            mem[fill_ptr].data   <= fill_data;
            mem[fill_ptr].filled <= 1'b1;
            fill_ptr             <= fill_ptr + 1'b1;
         end
         if (pop) begin
            mem[head].filled <= 1'b0;
            head             <= head + 1'b1;
         end
         case ({reserve, pop})
            2'b10:   slots <= slots + 1'b1;
            2'b01:   slots <= slots - 1'b1;
            default: slots <= slots;
         endcase
      end
   end

   assign head_valid = mem[head].filled;
   assign head_pc    = mem[head].pc;
   assign head_data  = mem[head].data;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, in-order memory requests, redirect flush and stale-response drop.
// Define FETCH_ALIGN_CHECK_EN to flag and stall on misaligned redirect targets.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              DEPTH    = 4
) (
   input logic                 clk,
   input logic                 rst,
   instruction_fetch_if.master bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0]   slots;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   drop;
   logic            req;
   logic            grant;
   logic            fill;
   logic            pop;
   logic            redirect;
   logic            stalled;
   logic            head_valid;
   logic [XLEN-1:0] head_pc;
   logic [ILEN-1:0] head_data;

`ifdef FETCH_ALIGN_CHECK_EN
   logic misaligned_q;

   // Sticky until the next redirect re-evaluates the target alignment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misaligned_q <= 1'b0;
      end else if (bus.redirect_valid) begin
         misaligned_q <= |bus.redirect_pc[1:0];
      end
   end

   assign stalled        = misaligned_q;
   assign bus.misaligned = misaligned_q;
`else
   assign stalled        = 1'b0;
   assign bus.misaligned = 1'b0;
`endif

   assign redirect = bus.redirect_valid;
   assign req      = !rst && (slots < CW'(DEPTH)) && (drop == '0) && !redirect && !stalled;
   assign grant    = req && bus.imem_gnt;
   assign fill     = bus.imem_rvalid && (drop == '0) && !redirect;
   assign pop      = head_valid && bus.inst_ready && !redirect;

   // inflight tracks every granted word not yet returned, live or stale, so a
   // redirect knows how many responses it must swallow before fetching again.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
      end else begin
         if (redirect) begin
            fetch_pc <= align_pc(bus.redirect_pc);
         end else if (grant) begin
            fetch_pc <= fetch_pc + XLEN'(PC_STEP);
         end

         case ({grant, bus.imem_rvalid})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase

         if (redirect) begin
            drop <= inflight - CW'(bus.imem_rvalid);
         end else if (bus.imem_rvalid && (drop != '0)) begin
            drop <= drop - 1'b1;
         end
      end
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect),
      .reserve    (grant),
      .reserve_pc (fetch_pc),
      .fill       (fill),
      .fill_data  (bus.imem_rdata),
      .pop        (pop),
      .head_valid (head_valid),
      .head_pc    (head_pc),
      .head_data  (head_data),
      .slots      (slots)
   );

   assign bus.imem_req    = req;
   assign bus.imem_addr   = fetch_pc;
   assign bus.inst_valid  = head_valid;
   assign bus.instruction = head_valid ? head_data : INST_NOP;
   assign bus.inst_pc     = head_valid ? head_pc : fetch_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: latency-configurable memory model,
// PC/data scoreboard, a redirect vector table and hand-written corner sequences.
module tb_instruction_fetch;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mem_req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [31:0] target;
      int          lat;
      bit          rnd;
      bit          exp_mis;
      bit          exp_pop;
      logic [31:0] exp_pc;
   } redir_vec_t;

   logic clk;
   logic rst;
   instruction_fetch_if bus();

   instruction_fetch #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          tests = 0;
   int          failed = 0;
   int          cyc = 0;
   int          lat = 1;
   bit          rnd = 1'b0;
   mem_req_t    mem_q[$];
   exp_t        exp_q[$];
   int          stale_cnt = 0;
   bit          cur_stale = 1'b0;
   logic [31:0] model_pc;
   int          grants = 0;
   int          pops = 0;
   int          first_valid_cyc = -1;
   bit          have_first = 1'b0;
   logic [31:0] first_pop_pc = '0;
   redir_vec_t  vecs[5];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // One clock: evaluate what the coming edge will do, then model the memory.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (!rst) begin
         if (bus.redirect_valid || stale_cnt > 0 || cur_stale)
            checkOutput("no_req_while_dropping", {31'b0, bus.imem_req}, 32'd0);
         if (bus.inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
            pops++;
            if (exp_q.size() == 0) begin
               checkOutput("pop_unexpected", bus.inst_pc, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               checkOutput("inst_pc", bus.inst_pc, e.pc);
               checkOutput("instruction", bus.instruction, e.data);
               if (!have_first) begin
                  have_first   = 1'b1;
                  first_pop_pc = bus.inst_pc;
               end
            end
         end
         if (bus.redirect_valid) begin
            exp_q.delete();
            stale_cnt  = mem_q.size();
            model_pc   = align_pc(bus.redirect_pc);
            have_first = 1'b0;
            pops       = 0;
         end
         if (bus.imem_req && bus.imem_gnt) begin
            checkOutput("imem_addr", bus.imem_addr, model_pc);
            exp_q.push_back('{pc: model_pc, data: mem_word(model_pc)});
            mem_q.push_back('{addr: bus.imem_addr, due: cyc + lat});
            model_pc = model_pc + 32'd4;
            grants++;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      bus.imem_rvalid = 1'b0;
      cur_stale       = 1'b0;
      if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
         mem_req_t m;
         m = mem_q.pop_front();
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = mem_word(m.addr);
         if (stale_cnt > 0) begin
            cur_stale = 1'b1;
            stale_cnt--;
         end
      end
      if (rnd) begin
         bus.imem_gnt   = 1'($urandom_range(0, 1));
         bus.inst_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic clearModel();
      mem_q.delete();
      exp_q.delete();
      stale_cnt       = 0;
      cur_stale       = 1'b0;
      model_pc        = RST_PC;
      grants          = 0;
      pops            = 0;
      first_valid_cyc = -1;
      have_first      = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.redirect_valid = 1'b0;
   endtask

   task automatic applyStimulus_reset(input int newlat);
      rst = 1'b1;
      lat = newlat;
      clearModel();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
      checkOutput("rst_imem_addr", bus.imem_addr, RST_PC);
      checkOutput("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
      checkOutput("rst_instruction", bus.instruction, INST_NOP);
      checkOutput("rst_inst_pc", bus.inst_pc, RST_PC);
      checkOutput("rst_misaligned", {31'b0, bus.misaligned}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 1;
      #1;
      checkOutput("first_req", {31'b0, bus.imem_req}, 32'd1);
      checkOutput("first_addr", bus.imem_addr, RST_PC);
   endtask

   task automatic applyStimulus_redirect(input logic [31:0] target, input int newlat,
                                         input bit exp_mis, input logic [31:0] exp_pc);
      bit idle;
      idle = (mem_q.size() == 0);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = target;
      lat                = newlat;
      tick();
      bus.redirect_valid = 1'b0;
      if (idle) begin
         #1;
         checkOutput("redirect_next_req", {31'b0, bus.imem_req}, {31'b0, !exp_mis});
         checkOutput("redirect_next_addr", bus.imem_addr, exp_pc);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vecs[0] = '{target: 32'h0000_0400, lat: 2, rnd: 1'b0, exp_mis: 1'b0, exp_pop: 1'b1, exp_pc: 32'h0000_0400};
`ifdef FETCH_ALIGN_CHECK_EN
      vecs[1] = '{target: 32'h0000_0202, lat: 1, rnd: 1'b0, exp_mis: 1'b1, exp_pop: 1'b0, exp_pc: 32'h0000_0200};
`else
      vecs[1] = '{target: 32'h0000_0202, lat: 1, rnd: 1'b0, exp_mis: 1'b0, exp_pop: 1'b1, exp_pc: 32'h0000_0200};
`endif
      vecs[2] = '{target: 32'h0000_0300, lat: 3, rnd: 1'b0, exp_mis: 1'b0, exp_pop: 1'b1, exp_pc: 32'h0000_0300};
      vecs[3] = '{target: 32'hFFFF_FFF8, lat: 1, rnd: 1'b0, exp_mis: 1'b0, exp_pop: 1'b1, exp_pc: 32'hFFFF_FFF8};
      vecs[4] = '{target: 32'h0000_1000, lat: 2, rnd: 1'b1, exp_mis: 1'b0, exp_pop: 1'b1, exp_pc: 32'h0000_1000};

      rst                = 1'b1;
      bus.imem_gnt       = 1'b1;
      bus.imem_rvalid    = 1'b0;
      bus.imem_rdata     = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.inst_ready     = 1'b1;

      // Streaming at latency 1: first valid in cycle 3, then one per cycle.
      applyStimulus_reset(1);
      repeat (20) tick();
      checkOutput("first_valid_cycle", first_valid_cyc, 32'd3);
      checkOutput("stream_pops", pops, 32'd18);

      // Decode stalls: requests stop at four slots, then drain in order.
      bus.inst_ready = 1'b0;
      applyStimulus_reset(1);
      repeat (10) tick();
      #1;
      checkOutput("full_grants", grants, 32'd4);
      checkOutput("full_req", {31'b0, bus.imem_req}, 32'd0);
      checkOutput("held_valid", {31'b0, bus.inst_valid}, 32'd1);
      checkOutput("held_pc", bus.inst_pc, RST_PC);
      checkOutput("held_data", bus.instruction, mem_word(RST_PC));
      bus.imem_gnt   = 1'b0;
      bus.inst_ready = 1'b1;
      repeat (6) tick();
      #1;
      checkOutput("drain_pops", pops, 32'd4);
      checkOutput("drain_left", exp_q.size(), 32'd0);
      checkOutput("drain_valid", {31'b0, bus.inst_valid}, 32'd0);

      // Withheld grant: request and address hold steady.
      for (int i = 0; i < 5; i++) begin
         tick();
         #1;
         checkOutput("nognt_req", {31'b0, bus.imem_req}, 32'd1);
         checkOutput("nognt_addr", bus.imem_addr, 32'h0000_0110);
      end
      bus.imem_gnt = 1'b1;
      repeat (2) tick();

      // Latency 3, two outstanding, redirect: both responses dropped first.
      applyStimulus_reset(3);
      repeat (2) tick();
      applyStimulus_redirect(32'h0000_0200, 3, 1'b0, 32'h0000_0200);
      repeat (2) tick();
      #1;
      checkOutput("resume_req", {31'b0, bus.imem_req}, 32'd1);
      checkOutput("resume_addr", bus.imem_addr, 32'h0000_0200);
      repeat (10) tick();
      checkOutput("resume_first_pc", first_pop_pc, 32'h0000_0200);

      // Redirect vector table.
      for (int i = 0; i < 5; i++) begin
         rnd = vecs[i].rnd;
         applyStimulus_redirect(vecs[i].target, vecs[i].lat, vecs[i].exp_mis, vecs[i].exp_pc);
         for (int k = 0; k < (vecs[i].rnd ? 30 : 12); k++) begin
            tick();
            if (vecs[i].exp_mis) begin
               #1;
               checkOutput("misaligned_stall", {31'b0, bus.imem_req}, 32'd0);
            end
         end
         checkOutput("misaligned", {31'b0, bus.misaligned}, {31'b0, vecs[i].exp_mis});
         checkOutput("vec_popped", {31'b0, (pops > 0)}, {31'b0, vecs[i].exp_pop});
         if (vecs[i].exp_pop) checkOutput("vec_first_pc", first_pop_pc, vecs[i].exp_pc);
         rnd            = 1'b0;
         bus.imem_gnt   = 1'b1;
         bus.inst_ready = 1'b1;
      end

      // Mid-operation reset with three buffered entries.
      bus.inst_ready = 1'b0;
      applyStimulus_redirect(32'h0000_0500, 1, 1'b0, 32'h0000_0500);
      grants = 0;
      begin
         int guard;
         guard = 0;
         while (grants < 3 && guard < 20) begin
            tick();
            guard++;
         end
         checkOutput("buffer_grants", grants, 32'd3);
      end
      bus.imem_gnt = 1'b0;
      repeat (3) tick();
      #1;
      checkOutput("buffered_valid", {31'b0, bus.inst_valid}, 32'd1);
      checkOutput("buffered_pc", bus.inst_pc, 32'h0000_0500);
      rst = 1'b1;
      #1;
      checkOutput("midrst_valid", {31'b0, bus.inst_valid}, 32'd0);
      checkOutput("midrst_req", {31'b0, bus.imem_req}, 32'd0);
      checkOutput("midrst_instruction", bus.instruction, INST_NOP);
      clearModel();
      bus.imem_gnt   = 1'b1;
      bus.inst_ready = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      cyc = 1;
      #1;
      checkOutput("postrst_req", {31'b0, bus.imem_req}, 32'd1);
      checkOutput("postrst_addr", bus.imem_addr, RST_PC);
      repeat (6) tick();
      checkOutput("postrst_first_pc", first_pop_pc, RST_PC);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
